// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI receiver: FSM state encoding,
// the tagged FIFO entry and the default transfer width.
package oled_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_PUSH
    } rx_state_t;

    typedef struct packed {
        logic                is_data;
        logic [SPI_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/oled_rx_fifo.sv
// Synchronous show-ahead FIFO for tagged receive bytes. Pointers carry one
// extra wrap bit so full/empty come from a plain MSB compare.
module oled_rx_fifo
    import oled_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = rx_entry_t
)
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   push_ok_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    entry_t      mem_q [DEPTH];
    logic        full;
    logic        popOk;
    logic        pushOk;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popOk   = pop_i && !empty_o;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign pushOk  = push_i && (!full || popOk);
    assign push_ok_o = pushOk;

    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushOk) wrPtr_d = wrPtr_q + PTR_ONE;
        if (popOk)  rdPtr_d = rdPtr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/oled_spi_receiver.sv
// Oversampling SPI Mode 3 receiver for the SSD1331-style OLED link; bytes are
// tagged by D/C and queued in a show-ahead FIFO. Optional per-tag byte counters
// are enabled with the OLED_SPI_RX_COUNTERS_EN macro.
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int BITS        = SPI_BITS,
    parameter int SYNC_STAGES = 2
)
(
    input  logic            sclk,
    input  logic            rst_n,
    input  logic            spi_clk,
    input  logic            cs,
    input  logic            mosi,
    input  logic            dc_c,
    output logic [BITS-1:0] rx_byte,
    output logic            rx_is_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            overflow,
    input  logic            ovf_clr,
    output logic            busy
`ifdef OLED_SPI_RX_COUNTERS_EN
    ,
    input  logic            cnt_clr,
    output logic [15:0]     cmd_count,
    output logic [15:0]     data_count
`endif
);

    typedef struct packed {
        logic            is_data;
        logic [BITS-1:0] data;
    } rx_word_t;

    localparam int CW = $clog2(BITS + 1);

    logic [1:0]             rstSync_q;
    logic                   rstInt_n;
    logic [SYNC_STAGES-1:0] clkSync_q, csSync_q, mosiSync_q, dcSync_q;
    logic                   clkS, csS;
    logic                   clkPrev_q, rise_q, bit_q, dc_q;

    rx_state_t       state_q, state_d;
    logic [CW-1:0]   bitCnt_q, bitCnt_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic            dcTag_q, dcTag_d;
    logic            frameErr_q, frameErr_d;
    logic            overflow_q, overflow_d;
    logic            push;
    logic            pushOk;
    logic            fifoEmpty;
    rx_word_t        head;

    // Reset asserts immediately but releases on sclk so nothing leaves reset mid-cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) rstSync_q <= '0;
        else        rstSync_q <= {rstSync_q[0], 1'b1};
    end
    assign rstInt_n = rstSync_q[1];

    always_ff @(posedge sclk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            clkSync_q  <= '1;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            dcSync_q   <= '0;
            clkPrev_q  <= 1'b1;
            rise_q     <= 1'b0;
            bit_q      <= 1'b0;
            dc_q       <= 1'b0;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], spi_clk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
            dcSync_q   <= {dcSync_q[SYNC_STAGES-2:0], dc_c};
            clkPrev_q  <= clkS;
            rise_q     <= clkS && !clkPrev_q && !csS;
            bit_q      <= mosiSync_q[SYNC_STAGES-1];
            dc_q       <= dcSync_q[SYNC_STAGES-1];
        end
    end

    assign clkS = clkSync_q[SYNC_STAGES-1];
    assign csS  = csSync_q[SYNC_STAGES-1];

    // A rise already in flight wins over a cs release, so the last bit is never lost.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        dcTag_d    = dcTag_q;
        frameErr_d = 1'b0;
        push       = 1'b0;
        case (state_q)
            RX_IDLE: begin
                bitCnt_d = '0;
                shift_d  = '0;
                if (!csS) state_d = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (rise_q) begin
                    shift_d  = {shift_q[BITS-2:0], bit_q};
                    bitCnt_d = bitCnt_q + CW'(1);
                    if (bitCnt_q == CW'(BITS - 1)) begin
                        dcTag_d = dc_q;
                        state_d = RX_PUSH;
                    end
                end else if (csS) begin
                    frameErr_d = (bitCnt_q != '0);
                    bitCnt_d   = '0;
                    state_d    = RX_IDLE;
                end
            end
            RX_PUSH: begin
                push     = 1'b1;
                bitCnt_d = '0;
                state_d  = csS ? RX_IDLE : RX_SHIFT;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr)               overflow_d = 1'b0;
        else if (push && !pushOk)  overflow_d = 1'b1;
    end

    always_ff @(posedge sclk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q    <= RX_IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            dcTag_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            dcTag_q    <= dcTag_d;
            frameErr_q <= frameErr_d;
            overflow_q <= overflow_d;
        end
    end

    oled_rx_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (rx_word_t)
    ) u_fifo (
        .clk_i     (sclk),
        .rst_ni    (rstInt_n),
        .push_i    (push),
        .wdata_i   ({dcTag_q, shift_q}),
        .pop_i     (rx_ready),
        .rdata_o   (head),
        .empty_o   (fifoEmpty),
        .push_ok_o (pushOk)
    );

    assign rx_byte    = head.data;
    assign rx_is_data = head.is_data;
    assign rx_valid   = !fifoEmpty;
    assign frame_err  = frameErr_q;
    assign overflow   = overflow_q;
    assign busy       = !csS;

`ifdef OLED_SPI_RX_COUNTERS_EN
    logic [15:0] cmdCnt_q, cmdCnt_d;
    logic [15:0] dataCnt_q, dataCnt_d;

    // Only bytes actually accepted by the FIFO count; both saturate at all-ones.
    always_comb begin
        cmdCnt_d  = cmdCnt_q;
        dataCnt_d = dataCnt_q;
        if (cnt_clr) begin
            cmdCnt_d  = '0;
            dataCnt_d = '0;
        end else if (pushOk) begin
            if (dcTag_q && dataCnt_q != 16'hFFFF)      dataCnt_d = dataCnt_q + 16'd1;
            else if (!dcTag_q && cmdCnt_q != 16'hFFFF) cmdCnt_d  = cmdCnt_q + 16'd1;
        end
    end

    always_ff @(posedge sclk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            cmdCnt_q  <= '0;
            dataCnt_q <= '0;
        end else begin
            cmdCnt_q  <= cmdCnt_d;
            dataCnt_q <= dataCnt_d;
        end
    end

    assign cmd_count  = cmdCnt_q;
    assign data_count = dataCnt_q;
`endif

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed self-checking bench for oled_spi_receiver: drives SPI Mode 3 at
// sclk/4 and compares FIFO output, flags and latency against hand-computed values.
module tb_oled_spi_receiver;

    logic       sclk = 1'b0;
    logic       rst_n, spi_clk, cs, mosi, dc_c;
    logic [7:0] rx_byte;
    logic       rx_is_data, rx_valid, rx_ready;
    logic       frame_err, overflow, ovf_clr, busy;
`ifdef OLED_SPI_RX_COUNTERS_EN
    logic        cnt_clr;
    logic [15:0] cmd_count, data_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] dataIn;
        logic       dcIn;
        logic [7:0] expByte;
        logic       expTag;
    } vec_t;

    vec_t vecs [5];

    always #5 sclk = ~sclk;

    oled_spi_receiver dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .cs         (cs),
        .mosi       (mosi),
        .dc_c       (dc_c),
        .rx_byte    (rx_byte),
        .rx_is_data (rx_is_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
`ifdef OLED_SPI_RX_COUNTERS_EN
        ,
        .cnt_clr    (cnt_clr),
        .cmd_count  (cmd_count),
        .data_count (data_count)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Sends the first nbits of b MSB-first; data changes on the falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic dc, input int nbits);
        dc_c = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            mosi    = b[7-i];
            repeat (2) @(negedge sclk);
            spi_clk = 1'b1;
            repeat (2) @(negedge sclk);
        end
    endtask

    task automatic csLow();
        cs = 1'b0;
        repeat (6) @(negedge sclk);
    endtask

    task automatic csHigh();
        repeat (2) @(negedge sclk);
        cs = 1'b1;
        repeat (8) @(negedge sclk);
    endtask

    task automatic popCheck(input string name, input logic [7:0] expByte, input logic expTag);
        checkOutput({name, "_valid"}, rx_valid, 1'b1);
        checkOutput({name, "_byte"}, rx_byte, expByte);
        checkOutput({name, "_tag"}, rx_is_data, expTag);
        rx_ready = 1'b1;
        @(negedge sclk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int errCount;
        rst_n = 1'b0; spi_clk = 1'b1; cs = 1'b1; mosi = 1'b0; dc_c = 1'b0;
        rx_ready = 1'b0; ovf_clr = 1'b0;
`ifdef OLED_SPI_RX_COUNTERS_EN
        cnt_clr = 1'b0;
`endif
        vecs[0] = '{8'h15, 1'b0, 8'h15, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h5F, 1'b1, 8'h5F, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1'b1};

        repeat (3) @(negedge sclk);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_byte", rx_byte, 8'h00);
        checkOutput("rst_tag", rx_is_data, 1'b0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge sclk);

        $display("[TB] basic byte with latency");
        csLow();
        checkOutput("busy_low", busy, 1'b1);
        applyStimulus(8'hAF, 1'b0, 7);
        spi_clk = 1'b0;
        mosi    = 1'b1;
        repeat (2) @(negedge sclk);
        spi_clk = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge sclk);
            checkOutput($sformatf("latency_k%0d", k), rx_valid, (k == 5) ? 1'b1 : 1'b0);
        end
        popCheck("basic", 8'hAF, 1'b0);
        checkOutput("basic_empty", rx_valid, 1'b0);
        csHigh();
        checkOutput("busy_high", busy, 1'b0);

        $display("[TB] mixed stream table");
        csLow();
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i].dataIn, vecs[i].dcIn, 8);
        csHigh();
        for (int i = 0; i < 5; i++) popCheck($sformatf("vec%0d", i), vecs[i].expByte, vecs[i].expTag);
        checkOutput("vec_empty", rx_valid, 1'b0);

        $display("[TB] framing error");
        csLow();
        applyStimulus(8'hFF, 1'b1, 5);
        repeat (2) @(negedge sclk);
        cs = 1'b1;
        errCount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sclk);
            if (frame_err) errCount++;
        end
        checkOutput("frame_err_pulses", errCount, 1);
        checkOutput("frame_no_write", rx_valid, 1'b0);
        csLow();
        applyStimulus(8'h81, 1'b0, 8);
        csHigh();
        checkOutput("frame_clean_err", frame_err, 1'b0);
        popCheck("after_frame", 8'h81, 1'b0);

        $display("[TB] overflow");
        csLow();
        for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 8);
        csHigh();
        checkOutput("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 16; i++) popCheck($sformatf("ovf%0d", i), 8'(i), 1'b1);
        checkOutput("ovf_drained", rx_valid, 1'b0);
        checkOutput("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge sclk);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", overflow, 1'b0);

        $display("[TB] full with simultaneous pop");
        csLow();
        for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 8);
        applyStimulus(8'h30, 1'b1, 7);
        spi_clk = 1'b0;
        mosi    = 1'b0;
        repeat (2) @(negedge sclk);
        spi_clk = 1'b1;
        repeat (4) @(negedge sclk);
        rx_ready = 1'b1;
        @(negedge sclk);
        rx_ready = 1'b0;
        csHigh();
        checkOutput("fullpop_no_ovf", overflow, 1'b0);
        for (int i = 1; i < 16; i++) popCheck($sformatf("fullpop%0d", i), 8'h20 + 8'(i), 1'b0);
        popCheck("fullpop_last", 8'h30, 1'b1);
        checkOutput("fullpop_empty", rx_valid, 1'b0);

        $display("[TB] async reset mid-byte");
        csLow();
        applyStimulus(8'h11, 1'b1, 8);
        applyStimulus(8'h22, 1'b0, 8);
        applyStimulus(8'hA5, 1'b1, 4);
        checkOutput("pre_rst_valid", rx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", rx_valid, 1'b0);
        checkOutput("async_rst_busy", busy, 1'b0);
        cs = 1'b1;
        spi_clk = 1'b1;
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sclk);
        checkOutput("post_rst_valid", rx_valid, 1'b0);
        csLow();
        applyStimulus(8'h3C, 1'b0, 8);
        csHigh();
        popCheck("post_rst", 8'h3C, 1'b0);
        checkOutput("post_rst_empty", rx_valid, 1'b0);

`ifdef OLED_SPI_RX_COUNTERS_EN
        $display("[TB] byte counters");
        cnt_clr = 1'b1;
        @(negedge sclk);
        cnt_clr = 1'b0;
        checkOutput("cnt_clr_cmd", cmd_count, 16'd0);
        checkOutput("cnt_clr_data", data_count, 16'd0);
        csLow();
        for (int i = 0; i < 3; i++) applyStimulus(8'h01 + 8'(i), 1'b0, 8);
        for (int i = 0; i < 5; i++) applyStimulus(8'h40 + 8'(i), 1'b1, 8);
        csHigh();
        checkOutput("cnt_cmd", cmd_count, 16'd3);
        checkOutput("cnt_data", data_count, 16'd5);
        cnt_clr = 1'b1;
        @(negedge sclk);
        cnt_clr = 1'b0;
        checkOutput("cnt_zero_cmd", cmd_count, 16'd0);
        checkOutput("cnt_zero_data", data_count, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
